// File: rtl/gpio_obi_banked_pkg.sv
// gpio_obi_banked_pkg: OBI types, register map and bank register layout for gpio_obi_banked
package gpio_obi_banked_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;
  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } gpio_obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } gpio_obi_rsp_t;
  localparam logic [31:0] BankStride = 32'h40;
  localparam logic [5:0] OffDir = 6'h00, OffEn = 6'h04, OffIn = 6'h08, OffOut = 6'h0C;
  localparam logic [5:0] OffSet = 6'h10, OffClr = 6'h14, OffToggle = 6'h18, OffIntrptEn = 6'h1C;
  localparam logic [5:0] OffStatus = 6'h20, OffModeLo = 6'h24, OffModeHi = 6'h28, OffDebounce = 6'h2C;
  localparam logic [31:0] BadRdata = 32'hBADC_AB1E;
  typedef enum logic [1:0] {RISE, FALL, ANY, LEVEL} gpio_intrpt_mode_e;
  typedef struct packed {
    logic [31:0] dir;
    logic [31:0] en;
    logic [31:0] out;
    logic [31:0] intrpt_en;
    logic [31:0] status;
    logic [31:0] mode_lo;
    logic [31:0] mode_hi;
    logic [31:0] debounce;
  } gpio_bank_regs_t;
  function automatic logic [31:0] spread16(input logic [15:0] v);
    for (int i = 0; i < 16; i++) spread16[2*i+:2] = {2{v[i]}};
  endfunction
  function automatic logic [31:0] bank_read(input gpio_bank_regs_t r, input logic [31:0] in_val,
                                            input logic [5:0] off);
    case (off)
      OffDir:      return r.dir;
      OffEn:       return r.en;
      OffIn:       return in_val;
      OffOut:      return r.out;
      OffIntrptEn: return r.intrpt_en;
      OffStatus:   return r.status;
      OffModeLo:   return r.mode_lo;
      OffModeHi:   return r.mode_hi;
      OffDebounce: return r.debounce;
      default:     return 32'h0;
    endcase
  endfunction
endpackage

// File: rtl/gpio_obi_banked_input_filter.sv
// gpio_input_filter: per-pin 2-FF synchroniser, debounce (GPIO_DEBOUNCE_EN) and interrupt event
module gpio_input_filter import gpio_obi_banked_pkg::*; #(
  parameter int DebounceWidth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pad_i,
  input  logic [DebounceWidth-1:0] threshold_i,
  input  gpio_intrpt_mode_e        mode_i,
  output logic                     filtered_o,
  output logic                     event_o
);
  logic [1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk) begin
    sync_q <= rst ? 2'b00 : {sync_q[0], pad_i};
    prev_q <= rst ? 1'b0 : filtered_o;
  end
`ifdef GPIO_DEBOUNCE_EN
  logic filt_q;
  logic [DebounceWidth-1:0] cnt_q;
  // >= lets a lowered threshold take effect on the very next mismatching cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (threshold_i == '0 || sync_q[1] == filt_q || cnt_q >= threshold_i) begin
      cnt_q  <= '0;
      filt_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign filtered_o = threshold_i == '0 ? sync_q[1] : filt_q;
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold_i;
  assign filtered_o = sync_q[1];
`endif
  assign event_o = mode_i == RISE ? filtered_o & ~prev_q :
                   mode_i == FALL ? ~filtered_o & prev_q :
                   mode_i == ANY  ? filtered_o ^ prev_q : filtered_o;
endmodule

// File: rtl/gpio_obi_banked.sv
// gpio_obi_banked: OBI GPIO with 32-pin register banks; GPIO_DEBOUNCE_EN adds debounce filters
module gpio_obi_banked import gpio_obi_banked_pkg::*; #(
  parameter obi_cfg_t ObiCfg        = ObiDefaultConfig,
  parameter type      obi_req_t     = gpio_obi_req_t,
  parameter type      obi_rsp_t     = gpio_obi_rsp_t,
  parameter int       GpioCount     = 32,
  parameter int       DebounceWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  obi_req_t             obi_req_i,
  output obi_rsp_t             obi_rsp_o,
  input  logic [GpioCount-1:0] gpio_in_i,
  output logic [GpioCount-1:0] gpio_out_o,
  output logic [GpioCount-1:0] gpio_out_en_o,
  output logic                 interrupt_o
);
  localparam int NumBanks = (GpioCount + 31) / 32;
  localparam int PadPins  = NumBanks * 32;
  gpio_bank_regs_t regs [NumBanks];
  logic [PadPins-1:0] filt, evt, irq_all;
  logic [31:0] bank_sel, bmask;
  logic [5:0] off;
  logic mapped, err_d, wr;
  logic [ObiCfg.DataWidth-1:0] rdata_d;
  logic rvalid_q, err_q;
  logic [31:0] rdata_q;
  logic [0:0] rid_q;
  logic unused_addr;
  assign bank_sel = obi_req_i.addr / BankStride;
  assign off = {obi_req_i.addr[5:2], 2'b00};
  assign unused_addr = ^obi_req_i.addr[1:0];
  assign bmask = {{8{obi_req_i.be[3]}}, {8{obi_req_i.be[2]}}, {8{obi_req_i.be[1]}}, {8{obi_req_i.be[0]}}};
  assign mapped = off <= OffDebounce;
  assign err_d = bank_sel >= 32'(NumBanks) || !mapped || (obi_req_i.we && off == OffIn);
  assign wr = obi_req_i.req && obi_req_i.we && !err_d;
  always_comb begin
    rdata_d = obi_req_i.we ? '0 : BadRdata;
    for (int b = 0; b < NumBanks; b++)
      if (!obi_req_i.we && !err_d && bank_sel == 32'(b)) rdata_d = bank_read(regs[b], filt[b*32+:32], off);
  end
  always_ff @(posedge clk_i) begin
    rvalid_q <= obi_req_i.req && !rst_i;
    rdata_q  <= rst_i ? '0 : rdata_d;
    err_q    <= rst_i ? 1'b0 : err_d;
    rid_q    <= rst_i ? '0 : obi_req_i.aid;
  end
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.rid    = rid_q;
    obi_rsp_o.err    = err_q;
  end
`ifdef GPIO_DEBOUNCE_EN
  localparam logic [31:0] DbMask = 32'((64'd1 << DebounceWidth) - 64'd1);
`endif
  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    // pins beyond GpioCount in the last bank are masked out of every write
    localparam logic [31:0] Valid = GpioCount >= (b + 1) * 32 ? 32'hFFFF_FFFF :
                                    (32'd1 << (GpioCount - b * 32)) - 32'd1;
    gpio_bank_regs_t r_q;
    logic sel;
    logic [31:0] m, d, ml, mh;
    assign sel = wr && bank_sel == 32'(b);
    assign m  = bmask & Valid;
    assign d  = obi_req_i.wdata & m;
    assign ml = bmask & spread16(Valid[15:0]);
    assign mh = bmask & spread16(Valid[31:16]);
`ifdef GPIO_DEBOUNCE_EN
    logic [31:0] db;
    assign db = bmask & DbMask;
`endif
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_q <= '0;
      end else begin
        r_q.dir       <= sel && off == OffDir ? (r_q.dir & ~m) | d : r_q.dir;
        r_q.en        <= sel && off == OffEn ? (r_q.en & ~m) | d : r_q.en;
        r_q.intrpt_en <= sel && off == OffIntrptEn ? (r_q.intrpt_en & ~m) | d : r_q.intrpt_en;
        r_q.out       <= !sel ? r_q.out :
                         off == OffOut    ? (r_q.out & ~m) | d :
                         off == OffSet    ? r_q.out | d :
                         off == OffClr    ? r_q.out & ~d :
                         off == OffToggle ? r_q.out ^ d : r_q.out;
        r_q.status    <= (r_q.status & ~(sel && off == OffStatus ? d : 32'h0)) | evt[b*32+:32];
        r_q.mode_lo   <= sel && off == OffModeLo ? (r_q.mode_lo & ~ml) | (obi_req_i.wdata & ml) : r_q.mode_lo;
        r_q.mode_hi   <= sel && off == OffModeHi ? (r_q.mode_hi & ~mh) | (obi_req_i.wdata & mh) : r_q.mode_hi;
`ifdef GPIO_DEBOUNCE_EN
        r_q.debounce  <= sel && off == OffDebounce ? (r_q.debounce & ~db) | (obi_req_i.wdata & db) : r_q.debounce;
`endif
      end
    end
    assign regs[b] = r_q;
    assign irq_all[b*32+:32] = r_q.status & r_q.intrpt_en;
  end
  for (genvar p = 0; p < PadPins; p++) begin : g_pin
    if (p < GpioCount) begin : g_used
      localparam int B = p / 32;
      localparam int I = p % 32;
      gpio_intrpt_mode_e mode;
      if (I < 16) begin : g_lo
        assign mode = gpio_intrpt_mode_e'(regs[B].mode_lo[2*I+:2]);
      end else begin : g_hi
        assign mode = gpio_intrpt_mode_e'(regs[B].mode_hi[2*I-32+:2]);
      end
      gpio_input_filter #(.DebounceWidth(DebounceWidth)) u_filter (
        .clk(clk_i),
        .rst(rst_i),
        .pad_i(gpio_in_i[p]),
        .threshold_i(regs[B].debounce[DebounceWidth-1:0]),
        .mode_i(mode),
        .filtered_o(filt[p]),
        .event_o(evt[p])
      );
      assign gpio_out_o[p]    = regs[B].out[I];
      assign gpio_out_en_o[p] = regs[B].dir[I] & regs[B].en[I];
    end else begin : g_pad
      assign filt[p] = 1'b0;
      assign evt[p]  = 1'b0;
    end
  end
  assign interrupt_o = |irq_all;
endmodule

// File: tb/tb_gpio_obi_banked.sv
// tb_gpio_obi_banked: table-driven and scoreboard-checked bench for gpio_obi_banked with 40 pins
module tb_gpio_obi_banked;
  import gpio_obi_banked_pkg::*;
  localparam int N = 40;
`ifdef GPIO_DEBOUNCE_EN
  localparam int Lat = 7;
  localparam logic [31:0] DbRead = 32'hFF;
`else
  localparam int Lat = 2;
  localparam logic [31:0] DbRead = 32'h0;
`endif
  typedef struct {
    logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic [31:0] rdata; logic err;
  } vec_t;
  typedef struct {logic chk_rd; logic [31:0] rdata; logic err; logic [0:0] rid; string tag;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  gpio_obi_req_t req;
  gpio_obi_rsp_t rsp;
  logic [N-1:0] gin, gout, goe;
  logic irq;
  int checks = 0, failures = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[$];
  logic exp_rv = 1'b0;
  logic [0:0] aid_n = 1'b0;
  always #5 clk = ~clk;
  gpio_obi_banked #(.GpioCount(N), .DebounceWidth(8)) dut (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req), .obi_rsp_o(rsp),
    .gpio_in_i(gin), .gpio_out_o(gout), .gpio_out_en_o(goe), .interrupt_o(irq)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] rdata, input logic err, input string tag);
    req.req = 1'b1; req.we = we; req.addr = addr; req.be = be; req.wdata = wdata; req.aid = aid_n;
    sb.push_back('{chk_rd: !we, rdata: rdata, err: err, rid: aid_n, tag: tag});
    aid_n = ~aid_n;
    @(posedge clk); #1;
    req.req = 1'b0;
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    xact(1'b1, addr, 4'hF, wdata, 32'h0, 1'b0, tag);
  endtask
  task automatic rd(input logic [31:0] addr, input logic [31:0] rdata, input string tag);
    xact(1'b0, addr, 4'hF, 32'h0, rdata, 1'b0, tag);
  endtask
  function automatic void v(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic err);
    vecs.push_back('{we: we, addr: addr, be: be, wdata: wdata, rdata: rdata, err: err});
  endfunction
  always @(posedge clk) exp_rv <= req.req && !rst;
  always @(negedge clk) begin
    if (req.req) check("gnt", rsp.gnt, 1);
    if (rsp.rvalid || exp_rv) check("rvalid", rsp.rvalid, exp_rv);
    if (rsp.rvalid) begin
      if (sb.size() == 0) check("sb_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        if (e.chk_rd) check({e.tag, "_rdata"}, rsp.rdata, e.rdata);
        check({e.tag, "_err"}, rsp.err, e.err);
        check({e.tag, "_rid"}, rsp.rid, e.rid);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    req = '0;
    gin = '0;
    v(1, 'h00, 4'hF, 32'hFFFF_FFFF, 0, 0);  v(1, 'h04, 4'hF, 32'hFFFF_FFFF, 0, 0);
    v(1, 'h0C, 4'hF, 32'hA5, 0, 0);         v(0, 'h0C, 4'hF, 0, 32'hA5, 0);
    v(1, 'h0C, 4'hF, 32'hF0, 0, 0);         v(1, 'h10, 4'hF, 32'h0F, 0, 0);
    v(1, 'h14, 4'hF, 32'h30, 0, 0);         v(1, 'h18, 4'hF, 32'h81, 0, 0);
    v(0, 'h0C, 4'hF, 0, 32'h4E, 0);         v(0, 'h10, 4'hF, 0, 32'h0, 0);
    v(0, 'h18, 4'hF, 0, 32'h0, 0);          v(1, 'h0C, 4'hF, 32'hF0F0, 0, 0);
    v(1, 'h10, 4'h2, 32'h0F0F, 0, 0);       v(1, 'h14, 4'h2, 32'h3030, 0, 0);
    v(1, 'h18, 4'h2, 32'h8181, 0, 0);       v(0, 'h0C, 4'hF, 0, 32'h4EF0, 0);
    v(1, 'h0C, 4'h1, 32'h1234_5678, 0, 0);  v(0, 'h0C, 4'hF, 0, 32'h4E78, 0);
    v(1, 'h4C, 4'hF, 32'hFFFF_FFFF, 0, 0);  v(0, 'h4C, 4'hF, 0, 32'hFF, 0);
    v(0, 'h40, 4'hF, 0, 32'h0, 0);          v(1, 'h64, 4'hF, 32'hFFFF_FFFF, 0, 0);
    v(0, 'h64, 4'hF, 0, 32'hFFFF, 0);       v(1, 'h68, 4'hF, 32'hFFFF_FFFF, 0, 0);
    v(0, 'h68, 4'hF, 0, 32'h0, 0);          v(1, 'h64, 4'hF, 32'h0, 0, 0);
    v(0, 'h8C, 4'hF, 0, 32'hBADC_AB1E, 1);  v(1, 'h80, 4'hF, 32'hFFFF_FFFF, 0, 1);
    v(0, 'h30, 4'hF, 0, 32'hBADC_AB1E, 1);  v(0, 'h3C, 4'hF, 0, 32'hBADC_AB1E, 1);
    v(1, 'h08, 4'hF, 32'hFFFF_FFFF, 0, 1);  v(0, 'h08, 4'hF, 0, 32'h0, 0);
    v(0, 'h0C, 4'hF, 0, 32'h4E78, 0);       v(1, 'h2C, 4'hF, 32'h1FF, 0, 0);
    v(0, 'h2C, 4'hF, 0, DbRead, 0);         v(1, 'h1C, 4'hF, 32'h8, 0, 0);
    v(0, 'h1C, 4'hF, 0, 32'h8, 0);          v(0, 'h20, 4'hF, 0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", gout, 0);
    check("reset_oe", goe, 0);
    check("reset_irq", irq, 0);
    check("reset_rvalid", rsp.rvalid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++)
      xact(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));
    @(posedge clk); #1;
    check("pads_out", gout, {8'hFF, 32'h0000_4E78});
    check("pads_oe", goe, {8'h00, 32'hFFFF_FFFF});
    check("irq_idle", irq, 0);
    wr('h2C, 32'h4, "db4");
`ifdef GPIO_DEBOUNCE_EN
    gin[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    gin[3] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rd('h08, 32'h0, "glitch_in");
    rd('h20, 32'h0, "glitch_status");
    check("glitch_irq", irq, 0);
`endif
    gin[3] = 1'b1;
    repeat (Lat - 1) @(posedge clk);
    #1;
    rd('h08, 32'h0, "in_before");
    check("irq_before", irq, 0);
    rd('h08, 32'h8, "in_after");
    check("irq_after", irq, 1);
    rd('h20, 32'h8, "status_rise");
    wr('h24, 32'hC0, "mode_level");
    wr('h20, 32'h8, "w1c_held");
    rd('h20, 32'h8, "status_set_wins");
    check("irq_held", irq, 1);
    gin[3] = 1'b0;
    repeat (Lat + 3) @(posedge clk);
    #1;
    wr('h20, 32'h8, "w1c_low");
    rd('h20, 32'h0, "status_cleared");
    check("irq_cleared", irq, 0);
    gin[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req.req = 1'b1; req.we = 1'b0; req.addr = 'h0C; req.be = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    req.req = 1'b0;
    check("rst_out", gout, 0);
    check("rst_oe", goe, 0);
    check("rst_irq", irq, 0);
    @(negedge clk);
    check("rst_dropped", rsp.rvalid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd('h0C, 32'h0, "rst_outreg");
    rd('h00, 32'h0, "rst_dir");
    rd('h2C, 32'h0, "rst_db");
    repeat (4) @(posedge clk);
    #1;
    rd('h08, 32'h8, "rst_in");
    rd('h20, 32'h8, "rst_status");
    check("rst_irq_gated", irq, 0);
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
